// File: rtl/reg_file_mp.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_mp
// Brief    : Multi-port register file with two write ports, NRD combinational
//            read ports and a per-register busy (reservation) scoreboard with
//            a registered busy count.
//            Optional macro REG_FILE_MP_BYPASS_EN: same-cycle write-to-read
//            bypass (write port 1 has priority over port 0).
// Revision : 1.0 - initial release
// ============================================================================
module reg_file_mp #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    parameter int AW       = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NRD*AW-1:0]    rd_adr,
    output logic [NRD*WIDTH-1:0] rd_data,
    output logic [NRD-1:0]       rd_busy,
    input  logic                 wr_en0,
    input  logic                 wr_en1,
    input  logic [AW-1:0]        wr_adr0,
    input  logic [AW-1:0]        wr_adr1,
    input  logic [WIDTH-1:0]     wr_data0,
    input  logic [WIDTH-1:0]     wr_data1,
    input  logic                 rsv_en,
    input  logic [AW-1:0]        rsv_adr,
    output logic [AW:0]          busy_cnt
);

    localparam bit c_ZERO = (ZERO_REG != 0);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic [AW:0]      busy_cnt_q;
    logic [AW:0]      busy_cnt_d;

    // Per-entry decoded hits; register 0 is locked out when hardwired to zero
    logic [DEPTH-1:0] w_hit0;
    logic [DEPTH-1:0] w_hit1;
    logic [DEPTH-1:0] w_rsv;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            localparam logic [AW-1:0] c_IDX    = AW'(gi);
            localparam bit            c_LOCKED = c_ZERO && (gi == 0);

            assign w_hit0[gi] = !c_LOCKED && wr_en0 && (wr_adr0 == c_IDX);
            assign w_hit1[gi] = !c_LOCKED && wr_en1 && (wr_adr1 == c_IDX);
            assign w_rsv[gi]  = !c_LOCKED && rsv_en && (rsv_adr == c_IDX);

            // Port 1 wins a same-address collision
            assign mem_d[gi]  = w_hit1[gi] ? wr_data1 :
                                (w_hit0[gi] ? wr_data0 : mem_q[gi]);
            // A reserve overrides a same-cycle write-back clear
            assign busy_d[gi] = w_rsv[gi] | (busy_q[gi] & ~(w_hit0[gi] | w_hit1[gi]));
        end
    endgenerate

    // Count the next-state busy bits so the count can never drift or wrap
    always_comb begin
        busy_cnt_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            busy_cnt_d = busy_cnt_d + (AW+1)'(busy_d[i]);
        end
    end

    // State registers: storage, busy bits and busy count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q      <= '{default: '0};
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            mem_q      <= mem_d;
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy_cnt = busy_cnt_q;

    generate
        for (genvar gk = 0; gk < NRD; gk++) begin : g_rd
            logic [AW-1:0]    w_ra;
            logic [WIDTH-1:0] w_d;
            logic             w_b;

            assign w_ra = rd_adr[gk*AW +: AW];

            // Read mux: stored state, optional bypass, zero register, reset blanking
            always_comb begin
                w_d = mem_q[w_ra];
                w_b = busy_q[w_ra];
`ifdef REG_FILE_MP_BYPASS_EN
                if (w_hit1[w_ra]) begin
                    w_d = wr_data1;
                    w_b = w_rsv[w_ra];
                end else if (w_hit0[w_ra]) begin
                    w_d = wr_data0;
                    w_b = w_rsv[w_ra];
                end
`endif
                if (c_ZERO && (w_ra == '0)) begin
                    w_d = '0;
                    w_b = 1'b0;
                end
                if (!rst) begin
                    w_d = '0;
                    w_b = 1'b0;
                end
            end

            assign rd_data[gk*WIDTH +: WIDTH] = w_d;
            assign rd_busy[gk]                = w_b;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_reg_file_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file_mp
// Brief    : Scoreboard bench for reg_file_mp (default parameters). Stimulus
//            pushes per-cycle expectations; a monitor pops and compares them
//            on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file_mp;

    localparam int WIDTH = 32;
    localparam int DEPTH = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;
`ifdef REG_FILE_MP_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                 clk;
    logic                 rst;
    logic [NRD*AW-1:0]    rd_adr;
    logic [NRD*WIDTH-1:0] rd_data;
    logic [NRD-1:0]       rd_busy;
    logic                 wr_en0, wr_en1;
    logic [AW-1:0]        wr_adr0, wr_adr1;
    logic [WIDTH-1:0]     wr_data0, wr_data1;
    logic                 rsv_en;
    logic [AW-1:0]        rsv_adr;
    logic [AW:0]          busy_cnt;

    reg_file_mp #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NRD(NRD), .ZERO_REG(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .rd_adr   (rd_adr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en0   (wr_en0),
        .wr_en1   (wr_en1),
        .wr_adr0  (wr_adr0),
        .wr_adr1  (wr_adr1),
        .wr_data0 (wr_data0),
        .wr_data1 (wr_data1),
        .rsv_en   (rsv_en),
        .rsv_adr  (rsv_adr),
        .busy_cnt (busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        b0;
        logic        b1;
        logic [5:0]  cnt;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
        end
    endtask

    // Monitor: outputs are stable mid-cycle, compare everything queued for this cycle
    initial begin
        exp_t it;
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                it = q.pop_front();
                cmp(it.nm, "d0",  rd_data[31:0],       it.d0);
                cmp(it.nm, "d1",  rd_data[63:32],      it.d1);
                cmp(it.nm, "b0",  {31'd0, rd_busy[0]}, {31'd0, it.b0});
                cmp(it.nm, "b1",  {31'd0, rd_busy[1]}, {31'd0, it.b1});
                cmp(it.nm, "cnt", {26'd0, busy_cnt},   {26'd0, it.cnt});
            end
        end
    end

    task automatic expect_now(input string nm, input logic [31:0] d0, input logic [31:0] d1,
                              input logic b0, input logic b1, input logic [5:0] cnt);
        exp_t e;
        e.nm = nm; e.d0 = d0; e.d1 = d1; e.b0 = b0; e.b1 = b1; e.cnt = cnt;
        q.push_back(e);
    endtask

    task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_adr = {a1, a0};
    endtask

    // Cross the next active edge, then return the write/reserve inputs to idle
    task automatic advance();
        @(posedge clk);
        #1;
        wr_en0 = 1'b0; wr_en1 = 1'b0; rsv_en = 1'b0;
    endtask

    task automatic step(input string nm, input logic [31:0] d0, input logic [31:0] d1,
                        input logic b0, input logic b1, input logic [5:0] cnt);
        expect_now(nm, d0, d1, b0, b1, cnt);
        advance();
    endtask

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        rd_adr = '0;
        wr_en0 = 1'b0; wr_en1 = 1'b0; rsv_en = 1'b0;
        wr_adr0 = '0; wr_adr1 = '0; rsv_adr = '0;
        wr_data0 = '0; wr_data1 = '0;
        @(posedge clk);
        #1;

        // Under reset, with a write and reserve presented
        rd(5'd5, 5'd5);
        wr_en0 = 1'b1; wr_adr0 = 5'd5; wr_data0 = 32'h5555_5555;
        rsv_en = 1'b1; rsv_adr = 5'd5;
        step("in_reset", 32'h0, 32'h0, 1'b0, 1'b0, 6'd0);

        // Release; read every address
        rst = 1'b1;
        for (int a = 0; a < DEPTH; a += 2) begin
            rd(AW'(a), AW'(a + 1));
            step("post_reset_read", 32'h0, 32'h0, 1'b0, 1'b0, 6'd0);
        end

        // Dual write to the same address: port 1 wins
        rd(5'd5, 5'd6);
        wr_en0 = 1'b1; wr_adr0 = 5'd5; wr_data0 = 32'hDEAD_BEEF;
        wr_en1 = 1'b1; wr_adr1 = 5'd5; wr_data1 = 32'h1234_5678;
        step("dual_wr", BYP ? 32'h1234_5678 : 32'h0, 32'h0, 1'b0, 1'b0, 6'd0);
        wr_en0 = 1'b1; wr_adr0 = 5'd9; wr_data0 = 32'h1111_1111;
        step("dual_wr_after", 32'h1234_5678, 32'h0, 1'b0, 1'b0, 6'd0);
        rd(5'd9, 5'd5);
        step("hold", 32'h1111_1111, 32'h1234_5678, 1'b0, 1'b0, 6'd0);

        // Reserve 3, 7, 3 again, then write 3
        rd(5'd3, 5'd7);
        rsv_en = 1'b1; rsv_adr = 5'd3;
        step("rsv3", 32'h0, 32'h0, 1'b0, 1'b0, 6'd0);
        rsv_en = 1'b1; rsv_adr = 5'd7;
        step("rsv7", 32'h0, 32'h0, 1'b1, 1'b0, 6'd1);
        rsv_en = 1'b1; rsv_adr = 5'd3;
        step("rsv3_again", 32'h0, 32'h0, 1'b1, 1'b1, 6'd2);
        wr_en0 = 1'b1; wr_adr0 = 5'd3; wr_data0 = 32'h0000_0033;
        step("wr3", BYP ? 32'h33 : 32'h0, 32'h0, BYP ? 1'b0 : 1'b1, 1'b1, 6'd2);
        step("after_wr3", 32'h33, 32'h0, 1'b0, 1'b1, 6'd1);

        // Register 0: write and reserve ignored
        rd(5'd0, 5'd3);
        wr_en0 = 1'b1; wr_adr0 = 5'd0; wr_data0 = 32'hFFFF_FFFF;
        rsv_en = 1'b1; rsv_adr = 5'd0;
        step("zero_wr", 32'h0, 32'h33, 1'b0, 1'b0, 6'd1);
        rd(5'd0, 5'd7);
        step("zero_after", 32'h0, 32'h0, 1'b0, 1'b1, 6'd1);

        // Reserve and write to the same address: data written, busy stays set
        rd(5'd12, 5'd7);
        rsv_en = 1'b1; rsv_adr = 5'd12;
        wr_en1 = 1'b1; wr_adr1 = 5'd12; wr_data1 = 32'hBBBB_0000;
        step("rsv_wr_same", BYP ? 32'hBBBB_0000 : 32'h0, 32'h0, 1'b0 | BYP, 1'b1, 6'd1);
        step("rsv_wr_after", 32'hBBBB_0000, 32'h0, 1'b1, 1'b1, 6'd2);

        // Write 9 while reading 9
        rd(5'd9, 5'd9);
        wr_en1 = 1'b1; wr_adr1 = 5'd9; wr_data1 = 32'hA5A5_A5A5;
        step("bypass9", BYP ? 32'hA5A5_A5A5 : 32'h1111_1111,
                        BYP ? 32'hA5A5_A5A5 : 32'h1111_1111, 1'b0, 1'b0, 6'd2);
        rd(5'd9, 5'd12);
        step("after9", 32'hA5A5_A5A5, 32'hBBBB_0000, 1'b0, 1'b1, 6'd2);

        // Reserve 4, then reset mid-cycle alongside a write to 4
        rd(5'd4, 5'd12);
        rsv_en = 1'b1; rsv_adr = 5'd4;
        step("rsv4", 32'h0, 32'hBBBB_0000, 1'b0, 1'b1, 6'd2);
        step("rsv4_after", 32'h0, 32'hBBBB_0000, 1'b1, 1'b1, 6'd3);
        wr_en0 = 1'b1; wr_adr0 = 5'd4; wr_data0 = 32'h0000_0044;
        expect_now("async_rst", 32'h0, 32'h0, 1'b0, 1'b0, 6'd0);
        #2;
        rst = 1'b0;
        advance();
        step("rst_hold", 32'h0, 32'h0, 1'b0, 1'b0, 6'd0);

        // First edge after release operates normally
        rst = 1'b1;
        wr_en1 = 1'b1; wr_adr1 = 5'd4; wr_data1 = 32'h0000_0044;
        rsv_en = 1'b1; rsv_adr = 5'd12;
        step("release", BYP ? 32'h44 : 32'h0, 32'h0, 1'b0, 1'b0, 6'd0);
        step("release_after", 32'h44, 32'h0, 1'b0, 1'b1, 6'd1);

        @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
